// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer around an 8-bit shift-left-by-one datapath with optional
// rotate, carry history and a start/busy/done handshake.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] count,
  input  logic             rotate,
  input  logic             abort,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] carries,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] carries_q, carries_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sat_count;

  assign sat_count = (count > MAX_CNT) ? MAX_CNT : count;

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    carries_d = carries_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dout_d    = din;
          carries_d = '0;
          cnt_d     = sat_count;
          mode_d    = rotate;
          state_d   = (sat_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // abort leaves the partial result untouched; no shift on that edge
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          dout_d    = {dout_q[WIDTH-2:0], mode_q & dout_q[WIDTH-1]};
          carries_d = {carries_q[WIDTH-2:0], dout_q[WIDTH-1]};
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy/done are registered copies of the upcoming state
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dout_q    <= '0;
      carries_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      carries_q <= carries_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout    = dout_q;
  assign carries = carries_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic [3:0] count;
   logic       rotate;
   logic       abort;
   logic [7:0] dout;
   logic [7:0] carries;
   logic       busy;
   logic       done;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [7:0] din;
      logic [3:0] count;
      logic       rotate;
      logic [7:0] expDout;
      logic [7:0] expCarries;
      int         expLatency;
   } vec_t;

   vec_t vecs[5];

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .din(din),
      .count(count),
      .rotate(rotate),
      .abort(abort),
      .dout(dout),
      .carries(carries),
      .busy(busy),
      .done(done)
   );

   // Shifting left n times is a multiply by 2^n in a 16-bit window: the upper
   // byte holds the bits that left the top, which are both the carry history
   // and (for rotate) the bits that re-enter at the bottom.
   function automatic void refModel(input logic [7:0] d, input int n, input logic r,
                                    output logic [7:0] eDout, output logic [7:0] eCarries);
      logic [15:0] wide;
      wide     = {8'h00, d} << n;
      eCarries = wide[15:8];
      eDout    = r ? (wide[7:0] | wide[15:8]) : wide[7:0];
   endfunction

   function automatic int satCount(input logic [3:0] c);
      return (c > 4'd8) ? 8 : int'(c);
   endfunction

   // Compares one observed value with its expected value and tallies the result
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp)
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      else
         passed++;
   endtask

   // Drives every request input in one go
   task automatic applyStimulus(input logic s, input logic [7:0] d, input logic [3:0] c,
                                input logic r, input logic a);
      start  = s;
      din    = d;
      count  = c;
      rotate = r;
      abort  = a;
   endtask

   // Advances to 1ns past the next rising edge, where outputs are sampled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request from IDLE and follows it until the done pulse (bounded)
   task automatic runTxn(input logic [7:0] d, input logic [3:0] c, input logic r, input logic a,
                         output logic [7:0] gDout, output logic [7:0] gCarries,
                         output int lat, output int busyCyc,
                         output logic postBusy, output logic postDone);
      applyStimulus(1'b1, d, c, r, a);
      tick();
      applyStimulus(1'b0, d, c, r, 1'b0);
      lat     = 0;
      busyCyc = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busyCyc++;
         tick();
         lat++;
      end
      if (busy === 1'b1) busyCyc++;
      gDout    = dout;
      gCarries = carries;
      tick();
      postBusy = busy;
      postDone = done;
   endtask

   initial begin
      logic [7:0] gDout, gCarries, eDout, eCarries;
      logic       postBusy, postDone, sawDone, sawBusy;
      int         lat, busyCyc, n, waited;
      logic [7:0] rd;
      logic [3:0] rc;
      logic       rr, ra;

      vecs[0] = '{8'hB1, 4'd2,  1'b0, 8'hC4, 8'h02, 2};
      vecs[1] = '{8'hA5, 4'd8,  1'b1, 8'hA5, 8'hA5, 8};
      vecs[2] = '{8'h81, 4'd1,  1'b1, 8'h03, 8'h01, 1};
      vecs[3] = '{8'h5A, 4'd0,  1'b0, 8'h5A, 8'h00, 0};
      vecs[4] = '{8'hFF, 4'd12, 1'b0, 8'h00, 8'hFF, 8};

      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_dout", dout, 8'h00);
      checkOutput("reset_carries", carries, 8'h00);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      // Directed vectors
      foreach (vecs[i]) begin
         runTxn(vecs[i].din, vecs[i].count, vecs[i].rotate, 1'b0,
                gDout, gCarries, lat, busyCyc, postBusy, postDone);
         checkOutput($sformatf("vec%0d_dout", i), gDout, vecs[i].expDout);
         checkOutput($sformatf("vec%0d_carries", i), gCarries, vecs[i].expCarries);
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLatency);
         checkOutput($sformatf("vec%0d_busy_cycles", i), busyCyc, vecs[i].expLatency + 1);
         checkOutput($sformatf("vec%0d_idle_after", i), {postBusy, postDone}, 2'b00);
      end

      // Abort after two shifts: partial result kept, no done pulse
      sawDone = 1'b0;
      applyStimulus(1'b1, 8'h01, 4'd5, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h01, 4'd5, 1'b0, 1'b0);
      tick(); sawDone |= done;
      tick(); sawDone |= done;
      abort = 1'b1;
      tick(); sawDone |= done;
      abort = 1'b0;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_dout", dout, 8'h04);
      checkOutput("abort_carries", carries, 8'h00);
      for (int k = 0; k < 4; k++) begin
         tick(); sawDone |= done;
      end
      checkOutput("abort_no_done", sawDone, 1'b0);
      runTxn(8'h01, 4'd3, 1'b0, 1'b0, gDout, gCarries, lat, busyCyc, postBusy, postDone);
      checkOutput("after_abort_dout", gDout, 8'h08);
      checkOutput("after_abort_latency", lat, 3);

      // start pulsed while shifting is ignored
      applyStimulus(1'b1, 8'h01, 4'd4, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'hFF, 4'd4, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'hFF, 4'd4, 1'b0, 1'b0);
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checkOutput("ignored_start_done_seen", done, 1'b1);
      checkOutput("ignored_start_dout", dout, 8'h10);
      checkOutput("ignored_start_carries", carries, 8'h00);
      tick();

      // start held high across DONE is only accepted once back in IDLE
      applyStimulus(1'b1, 8'h33, 4'd1, 1'b0, 1'b0);
      tick();
      checkOutput("held_shift_busy", {busy, done}, 2'b10);
      tick();
      checkOutput("held_done_pulse", {busy, done}, 2'b11);
      checkOutput("held_done_dout", dout, 8'h66);
      tick();
      checkOutput("held_idle", {busy, done}, 2'b00);
      checkOutput("held_idle_dout", dout, 8'h66);
      tick();
      checkOutput("held_reaccept_busy", busy, 1'b1);
      checkOutput("held_reaccept_dout", dout, 8'h33);
      start = 1'b0;
      tick();
      checkOutput("held_second_done", {done, dout}, {1'b1, 8'h66});
      tick();

      // Asynchronous reset between edges mid-shift
      applyStimulus(1'b1, 8'hAA, 4'd8, 1'b1, 1'b0);
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_dout", dout, 8'h00);
      checkOutput("async_rst_carries", carries, 8'h00);
      checkOutput("async_rst_busy", busy, 1'b0);
      checkOutput("async_rst_done", done, 1'b0);
      #1;
      rst = 1'b0;
      sawDone = 1'b0;
      sawBusy = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         sawDone |= done;
         sawBusy |= busy;
      end
      checkOutput("post_rst_quiet", {sawBusy, sawDone}, 2'b00);
      runTxn(8'h96, 4'd3, 1'b1, 1'b0, gDout, gCarries, lat, busyCyc, postBusy, postDone);
      refModel(8'h96, 3, 1'b1, eDout, eCarries);
      checkOutput("post_rst_dout", gDout, eDout);
      checkOutput("post_rst_carries", gCarries, eCarries);

      // Randomized transactions; abort raised together with start must be ignored
      for (int t = 0; t < 40; t++) begin
         rd = 8'($urandom_range(0, 255));
         rc = 4'($urandom_range(0, 15));
         rr = 1'($urandom_range(0, 1));
         ra = 1'($urandom_range(0, 1));
         n  = satCount(rc);
         refModel(rd, n, rr, eDout, eCarries);
         runTxn(rd, rc, rr, ra, gDout, gCarries, lat, busyCyc, postBusy, postDone);
         checkOutput($sformatf("rand%0d_dout", t), gDout, eDout);
         checkOutput($sformatf("rand%0d_carries", t), gCarries, eCarries);
         checkOutput($sformatf("rand%0d_latency", t), lat, n);
         checkOutput($sformatf("rand%0d_post", t), {postBusy, postDone}, 2'b00);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer around the 8-bit shift-left-by-one datapath (bit 0 fed with 0, bit 7 leaves as carry-out). It loads an operand, applies the single-bit shift once per clock for a requested count (0..8), and optionally recirculates the carry into bit 0 (rotate). Each shifted-out bit is recorded in a carry-history register. A start/busy/done handshake sits toward the requesting logic.

Parameters:
WIDTH, 8, operand width; fixed to match the shift datapath.
CNT_W, 4, width of the count input; values above WIDTH saturate.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
din  input  8  operand latched on start acceptance
count  input  4  number of shifts; values >8 are treated as 8
rotate  input  1  latched on start; 1 feeds the carry-out back into bit 0, 0 feeds 0
abort  input  1  terminates an active SHIFT sequence
dout  output  8  working/result register
carries  output  8  carry history; newest shifted-out bit in bit 0
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- rst asserted at any time, including mid-sequence: state=IDLE, dout=0x00, carries=0x00, busy=0, done=0, internal counter=0, latched rotate=0. Takes effect immediately, not at the next edge.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, start=1 at edge E0 (accept):
  - dout<=din, carries<=0x00, cnt<=min(count,8), mode<=rotate.
  - Next state is SHIFT if cnt>0, otherwise DONE.
- IDLE, start=0: hold all registers.
- SHIFT, each edge:
  - dout<={dout[6:0], mode ? dout[7] : 0}.
  - carries<={carries[6:0], dout[7]}.
  - cnt<=cnt-1.
  - When cnt==1 at the edge, the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. dout and carries hold.
- Latency: for N=min(count,8), done is high during the cycle following edge E0+N. N=0 gives done right after E0 with dout=din and carries=0.
- busy=1 in SHIFT and DONE. start is ignored while busy=1; no queuing.
- abort=1 in SHIFT:
  - The next edge goes to IDLE with no shift performed on that edge.
  - done is not asserted.
  - dout and carries hold their partial values.
- abort in IDLE or DONE: ignored. In DONE, done is still issued.
- start and abort both high in IDLE: start is accepted and abort is ignored.
- Wrap/limits:
  - carries keeps only the last 8 shifted-out bits. The full 8 bits are always meaningful after 8 shifts.
  - The counter never underflows.

Test Plan:
- din=0xB1, count=2, rotate=0 -> done after E0+2, dout=0xC4, carries=0x02, busy high for 3 cycles.
- din=0xA5, count=8, rotate=1 -> dout=0xA5, carries=0xA5, done after E0+8. Also din=0x81, count=1, rotate=1 -> dout=0x03, carries=0x01.
- din=0x5A, count=0 -> done the cycle after E0, dout=0x5A, carries=0x00. din=0xFF, count=12, rotate=0 -> saturates to 8, dout=0x00, carries=0xFF, done after E0+8.
- din=0x01, count=5: abort at the edge after 2 shifts -> IDLE, dout=0x04, carries=0x00, done never asserted. A following start with din=0x01, count=3 is accepted -> dout=0x08.
- start pulsed with din=0xFF during SHIFT of din=0x01, count=4 -> ignored, final dout=0x10. start held high across DONE -> accepted only once state is IDLE.
- rst asserted asynchronously mid-SHIFT (between edges) -> dout, carries, busy and done go to 0 immediately. No done after rst deasserts. Normal operation resumes on the next start.
